down_timer: RTL and testbench



---
 rtl/down_timer.sv | 106 ++++++++++
 tb/tb_down_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: programmable one-shot/periodic down counter with pause; DOWN_TIMER_PRESCALE_EN adds a PRESCALE-cycle decrement prescaler.
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] count_n, reload_reg, reload_n;
  logic mode_reg, mode_n, done_n, tick;
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end
`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre, pre_n;
  assign tick = pre == PMAX;
`else
  assign tick = 1'b1;
`endif
  assign busy   = state != IDLE;
  assign paused = state == PAUSE;
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    mode_n   = mode_reg;
    done_n   = 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
    pre_n    = pre;
`endif
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
`ifdef DOWN_TIMER_PRESCALE_EN
      pre_n   = '0;
`endif
    end else begin
      case (state)
        IDLE: if (start && load_val != '0) begin
          state_n  = RUN;
          count_n  = load_val;
          reload_n = load_val;
          mode_n   = auto_reload;
`ifdef DOWN_TIMER_PRESCALE_EN
          pre_n    = '0;
`endif
        end
        RUN: if (stop) begin
          state_n = PAUSE;
        end else if (tick) begin
`ifdef DOWN_TIMER_PRESCALE_EN
          pre_n = '0;
`endif
          // terminal count: one-shot returns to IDLE, periodic reloads and keeps running
          if (count > WIDTH'(1)) begin
            count_n = count - WIDTH'(1);
          end else begin
            done_n  = 1'b1;
            count_n = mode_reg ? reload_reg : '0;
            state_n = mode_reg ? RUN : IDLE;
          end
        end else begin
`ifdef DOWN_TIMER_PRESCALE_EN
          pre_n = pre + PW'(1);
`endif
        end
        PAUSE: state_n = (start && !stop) ? RUN : PAUSE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= IDLE;
      count      <= '0;
      done       <= 1'b0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
      pre        <= '0;
`endif
    end else begin
      state      <= state_n;
      count      <= count_n;
      done       <= done_n;
      reload_reg <= reload_n;
      mode_reg   <= mode_n;
`ifdef DOWN_TIMER_PRESCALE_EN
      pre        <= pre_n;
`endif
    end
  end
endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer: directed self-checking bench for down_timer (default build, no prescaler).
module tb_down_timer;
  logic clk = 1'b0;
  logic res, auto_reload, start, stop, clear;
  logic [7:0] load_val, count;
  logic busy, paused, done;
  int checks = 0;
  int errors = 0;
  int early;
  down_timer #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk(clk), .res(res), .load_val(load_val), .auto_reload(auto_reload),
    .start(start), .stop(stop), .clear(clear),
    .count(count), .busy(busy), .paused(paused), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  initial begin
    res = 1'b1; load_val = '0; auto_reload = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    step; step;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_paused", paused, 0);
    chk("rst_done", done, 0);
    res = 1'b0; load_val = 8'd5; start = 1'b1;
    step;
    chk("os_load", count, 5);
    chk("os_busy0", busy, 1);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step;
      chk("os_count", count, 5 - k);
      chk("os_done", done, k == 5);
      chk("os_busy", busy, k != 5);
    end
    step;
    chk("os_done_once", done, 0);
    chk("os_idle_count", count, 0);
    load_val = 8'd3; auto_reload = 1'b1; start = 1'b1;
    step;
    chk("per_load", count, 3);
    start = 1'b0; auto_reload = 1'b0; load_val = 8'd9;
    for (int k = 1; k <= 7; k++) begin
      step;
      chk("per_count", count, (k % 3 == 0) ? 3 : 3 - (k % 3));
      chk("per_done", done, k % 3 == 0);
      chk("per_busy", busy, 1);
    end
    clear = 1'b1;
    step;
    clear = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("clr_quiet", {done, busy}, 0);
    end
    load_val = 8'd10; start = 1'b1;
    step;
    start = 1'b0;
    chk("pr_load", count, 10);
    step; step; step;
    chk("pr_at7", count, 7);
    stop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("pr_hold", count, 7);
      chk("pr_paused", paused, 1);
      chk("pr_busy", busy, 1);
      chk("pr_nodone", done, 0);
    end
    stop = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    chk("pr_resume_count", count, 7);
    chk("pr_resume_paused", paused, 0);
    for (int k = 1; k <= 7; k++) begin
      step;
      chk("pr_count", count, 7 - k);
      chk("pr_done", done, k == 7);
    end
    load_val = 8'd0; start = 1'b1;
    step;
    start = 1'b0;
    chk("zero_busy", busy, 0);
    chk("zero_done", done, 0);
    chk("zero_count", count, 0);
    load_val = 8'd6; start = 1'b1;
    step;
    chk("rs_load", count, 6);
    step;
    chk("rs_ignored", count, 5);
    stop = 1'b1;
    step;
    chk("ss_run_count", count, 5);
    chk("ss_run_paused", paused, 1);
    step;
    chk("ss_pause_paused", paused, 1);
    chk("ss_pause_count", count, 5);
    start = 1'b0; stop = 1'b0; clear = 1'b1;
    step;
    clear = 1'b0;
    chk("ss_clear", {busy, paused}, 0);
    load_val = 8'd255; start = 1'b1;
    step;
    start = 1'b0;
    chk("max_load", count, 255);
    early = 0;
    for (int k = 1; k < 255; k++) begin
      step;
      if (done) early++;
    end
    chk("max_early", early, 0);
    chk("max_count1", count, 1);
    step;
    chk("max_done", done, 1);
    chk("max_count0", count, 0);
    load_val = 8'd4; start = 1'b1;
    step;
    start = 1'b0;
    step; step;
    chk("sr_pre", count, 2);
    res = 1'b1;
    #2;
    chk("sr_async_count", count, 2);
    chk("sr_async_busy", busy, 1);
    step;
    res = 1'b0;
    chk("sr_count", count, 0);
    chk("sr_busy", busy, 0);
    chk("sr_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      step;
      chk("sr_quiet", {done, busy}, 0);
    end
    load_val = 8'd2; start = 1'b1;
    step;
    start = 1'b0;
    step;
    chk("srd_count1", count, 1);
    res = 1'b1;
    step;
    res = 1'b0;
    chk("srd_done", done, 0);
    chk("srd_count", count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
